// File: rtl/dm_arbiter.sv
// Data-memory port arbiter between the MEM stage and a debug/loader master.
// Fixed-occupancy accesses, CPU priority with a starvation guard for debug.
module dm_arbiter #(
  parameter int LAT = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_read,
  input  logic        i_cpu_write,
  input  logic [31:0] i_cpu_addr,
  input  logic [31:0] i_cpu_wdata,
  output logic [31:0] o_cpu_rdata,
  output logic        o_stall,
  input  logic        i_dbg_req,
  input  logic        i_dbg_we,
  input  logic [31:0] i_dbg_addr,
  input  logic [31:0] i_dbg_wdata,
  output logic        o_dbg_gnt,
  output logic        o_dbg_done,
  output logic [31:0] o_dbg_rdata,
  output logic        o_dm_read,
  output logic        o_dm_write,
  output logic [31:0] o_dm_addr,
  output logic [31:0] o_dm_wdata,
  input  logic [31:0] i_dm_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DBG_ACC = 2'd2
  } state_t;

  localparam logic [2:0] LAST = 3'(LAT - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_cnt;
  logic [2:0]  w_cnt_nxt;
  logic [1:0]  r_starve;
  logic [1:0]  w_starve_nxt;
  logic        r_dbg_we;
  logic [31:0] r_dbg_addr;
  logic [31:0] r_dbg_wdata;
  logic [31:0] r_dbg_rdata;
  logic        r_dbg_done;

  logic        w_cpu_req;
  logic        w_last;
  logic        w_gnt_dbg;
  logic        w_gnt_cpu;
  logic        w_dbg_fin;
  logic        w_dm_read;
  logic        w_dm_write;
  logic [31:0] w_dm_addr;
  logic [31:0] w_dm_wdata;
  logic [31:0] w_cpu_rdata;
  logic        w_dbg_gnt;

  assign w_cpu_req = i_cpu_read | i_cpu_write;
  assign w_last    = (r_cnt == LAST);
  assign w_gnt_dbg = i_dbg_req &
                     ((r_starve == 2'd2) | ~w_cpu_req);
  assign w_gnt_cpu = w_cpu_req & ~w_gnt_dbg;
  assign w_dbg_fin = (r_state == DBG_ACC) & w_last;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 3'd0;
      r_starve <= 2'd0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_starve <= w_starve_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_starve_nxt = r_starve;
    w_dm_read    = 1'b0;
    w_dm_write   = 1'b0;
    w_dm_addr    = 32'd0;
    w_dm_wdata   = 32'd0;
    w_cpu_rdata  = 32'd0;
    w_dbg_gnt    = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_cnt_nxt = 3'd0;
        if (w_gnt_dbg) begin
          w_state_nxt  = DBG_ACC;
          w_starve_nxt = 2'd0;
        end else if (w_gnt_cpu) begin
          w_state_nxt = CPU_ACC;
          if (!i_dbg_req)
            w_starve_nxt = 2'd0;
          else if (r_starve != 2'd2)
            w_starve_nxt = r_starve + 2'd1;
        end
      end
      CPU_ACC: begin
        w_cnt_nxt   = w_last ? 3'd0 : r_cnt + 3'd1;
        w_state_nxt = w_last ? IDLE : CPU_ACC;
        // Write wins when the stage raises both strobes
        w_dm_write  = i_cpu_write;
        w_dm_read   = i_cpu_read & ~i_cpu_write;
        w_dm_addr   = i_cpu_addr;
        w_dm_wdata  = i_cpu_wdata;
        w_cpu_rdata = i_dm_rdata;
      end
      DBG_ACC: begin
        w_cnt_nxt   = w_last ? 3'd0 : r_cnt + 3'd1;
        w_state_nxt = w_last ? IDLE : DBG_ACC;
        w_dm_write  = r_dbg_we;
        w_dm_read   = ~r_dbg_we;
        w_dm_addr   = r_dbg_addr;
        w_dm_wdata  = r_dbg_wdata;
        w_dbg_gnt   = (r_cnt == 3'd0);
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dbg_we    <= 1'b0;
      r_dbg_addr  <= 32'd0;
      r_dbg_wdata <= 32'd0;
      r_dbg_rdata <= 32'd0;
      r_dbg_done  <= 1'b0;
    end else begin
      if ((r_state == IDLE) && w_gnt_dbg) begin
        r_dbg_we    <= i_dbg_we;
        r_dbg_addr  <= i_dbg_addr;
        r_dbg_wdata <= i_dbg_wdata;
      end
      r_dbg_done <= w_dbg_fin;
      if (w_dbg_fin && !r_dbg_we)
        r_dbg_rdata <= i_dm_rdata;
    end
  end

  // Reset gates the memory side combinationally, even mid-access
  assign o_dm_read   = w_dm_read & i_rst_n;
  assign o_dm_write  = w_dm_write & i_rst_n;
  assign o_dm_addr   = i_rst_n ? w_dm_addr : 32'd0;
  assign o_dm_wdata  = i_rst_n ? w_dm_wdata : 32'd0;
  assign o_stall     = i_rst_n & w_cpu_req &
                       ~((r_state == CPU_ACC) & w_last);
  assign o_cpu_rdata = w_cpu_rdata;
  assign o_dbg_gnt   = w_dbg_gnt;
  assign o_dbg_done  = r_dbg_done;
  assign o_dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: LAT=2 main instance, LAT=1 side instance.
module tb_dm_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_read = 0, cpu_write = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0;
  logic        dbg_req = 0, dbg_we = 0;
  logic [31:0] dbg_addr = 0, dbg_wdata = 0;
  logic [31:0] cpu_rdata, dbg_rdata, dm_addr, dm_wdata, dm_rdata;
  logic        stall, dbg_gnt, dbg_done, dm_read, dm_write;

  logic        c1_read = 0, c1_write = 0;
  logic [31:0] c1_addr = 0, c1_wdata = 0;
  logic        z_req = 0, z_we = 0;
  logic [31:0] z_addr = 0, z_wdata = 0;
  logic [31:0] c1_rdata, c1_dbg_rdata, c1_dm_addr, c1_dm_wdata, c1_dm_rdata;
  logic        c1_stall, c1_gnt, c1_done, c1_dm_read, c1_dm_write;

  int n_run = 0;
  int n_fail = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    case (a)
      32'h10:  return 32'hCAFE0001;
      32'h20:  return 32'h5A5A5A5A;
      default: return a ^ 32'hA5000000;
    endcase
  endfunction

  assign dm_rdata    = mem(dm_addr);
  assign c1_dm_rdata = mem(c1_dm_addr);

  dm_arbiter #(.LAT(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_read(cpu_read), .i_cpu_write(cpu_write),
    .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_stall(stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we),
    .i_dbg_addr(dbg_addr), .i_dbg_wdata(dbg_wdata),
    .o_dbg_gnt(dbg_gnt), .o_dbg_done(dbg_done),
    .o_dbg_rdata(dbg_rdata),
    .o_dm_read(dm_read), .o_dm_write(dm_write),
    .o_dm_addr(dm_addr), .o_dm_wdata(dm_wdata),
    .i_dm_rdata(dm_rdata)
  );

  dm_arbiter #(.LAT(1)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_read(c1_read), .i_cpu_write(c1_write),
    .i_cpu_addr(c1_addr), .i_cpu_wdata(c1_wdata),
    .o_cpu_rdata(c1_rdata), .o_stall(c1_stall),
    .i_dbg_req(z_req), .i_dbg_we(z_we),
    .i_dbg_addr(z_addr), .i_dbg_wdata(z_wdata),
    .o_dbg_gnt(c1_gnt), .o_dbg_done(c1_done),
    .o_dbg_rdata(c1_dbg_rdata),
    .o_dm_read(c1_dm_read), .o_dm_write(c1_dm_write),
    .o_dm_addr(c1_dm_addr), .o_dm_wdata(c1_dm_wdata),
    .i_dm_rdata(c1_dm_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    cpu_read = 1; c1_read = 1;
    #1;
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got %0h want 0", stall); end
    n_run++; if (c1_stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall1 got %0h want 0", c1_stall); end
    tick();
    n_run++; if (dm_read !== 1'b0) begin n_fail++; $display("FAIL rst_dm_read got %0h want 0", dm_read); end
    n_run++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL rst_done got %0h want 0", dbg_done); end
    n_run++; if (dbg_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_dbg_rdata got %h want 0", dbg_rdata); end
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall_edge got %0h want 0", stall); end
    cpu_read = 0; c1_read = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_cpu_read;
    tick();
    cpu_read = 1; cpu_addr = 32'h10;
    #1;
    n_run++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rd_stall0 got %0h want 1", stall); end
    n_run++; if (dm_read !== 1'b0) begin n_fail++; $display("FAIL rd_idle_read got %0h want 0", dm_read); end
    tick(); #1;
    n_run++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rd_stall1 got %0h want 1", stall); end
    n_run++; if (dm_read !== 1'b1) begin n_fail++; $display("FAIL rd_read1 got %0h want 1", dm_read); end
    n_run++; if (dm_addr !== 32'h10) begin n_fail++; $display("FAIL rd_addr got %h want 10", dm_addr); end
    tick(); #1;
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rd_stall2 got %0h want 0", stall); end
    n_run++; if (dm_read !== 1'b1) begin n_fail++; $display("FAIL rd_read2 got %0h want 1", dm_read); end
    n_run++; if (cpu_rdata !== 32'hCAFE0001) begin n_fail++; $display("FAIL rd_data got %h want cafe0001", cpu_rdata); end
    tick();
    cpu_read = 0;
    #1;
    n_run++; if (dm_read !== 1'b0) begin n_fail++; $display("FAIL rd_after got %0h want 0", dm_read); end
    n_run++; if (cpu_rdata !== 32'd0) begin n_fail++; $display("FAIL rd_rdata_idle got %h want 0", cpu_rdata); end
  endtask

  task automatic test_dbg_read;
    tick();
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    #1;
    n_run++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL dr_gnt0 got %0h want 0", dbg_gnt); end
    tick(); #1;
    n_run++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL dr_gnt1 got %0h want 1", dbg_gnt); end
    n_run++; if (dm_read !== 1'b1) begin n_fail++; $display("FAIL dr_read got %0h want 1", dm_read); end
    n_run++; if (dm_addr !== 32'h20) begin n_fail++; $display("FAIL dr_addr got %h want 20", dm_addr); end
    dbg_req = 0; dbg_addr = 32'h0;
    tick(); #1;
    n_run++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL dr_gnt2 got %0h want 0", dbg_gnt); end
    n_run++; if (dm_addr !== 32'h20) begin n_fail++; $display("FAIL dr_addr_held got %h want 20", dm_addr); end
    n_run++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL dr_done_early got %0h want 0", dbg_done); end
    tick(); #1;
    n_run++; if (dbg_done !== 1'b1) begin n_fail++; $display("FAIL dr_done got %0h want 1", dbg_done); end
    n_run++; if (dbg_rdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL dr_rdata got %h want 5a5a5a5a", dbg_rdata); end
    n_run++; if (dm_read !== 1'b0) begin n_fail++; $display("FAIL dr_idle got %0h want 0", dm_read); end
    tick(); #1;
    n_run++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL dr_done_pulse got %0h want 0", dbg_done); end
  endtask

  task automatic test_dbg_write;
    tick();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h30; dbg_wdata = 32'h11223344;
    tick(); #1;
    n_run++; if (dm_write !== 1'b1) begin n_fail++; $display("FAIL dw_write got %0h want 1", dm_write); end
    n_run++; if (dm_read !== 1'b0) begin n_fail++; $display("FAIL dw_read got %0h want 0", dm_read); end
    n_run++; if (dm_wdata !== 32'h11223344) begin n_fail++; $display("FAIL dw_wdata got %h want 11223344", dm_wdata); end
    dbg_req = 0; dbg_we = 0; dbg_wdata = 0;
    tick(); tick(); #1;
    n_run++; if (dbg_done !== 1'b1) begin n_fail++; $display("FAIL dw_done got %0h want 1", dbg_done); end
    n_run++; if (dbg_rdata !== 32'h5A5A5A5A) begin n_fail++; $display("FAIL dw_rdata_kept got %h want 5a5a5a5a", dbg_rdata); end
  endtask

  task automatic test_starvation;
    logic [11:0] exp_stall;
    exp_stall = 12'b0111_1101_1011;
    tick();
    cpu_read = 1; cpu_addr = 32'h40;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    for (int i = 0; i < 12; i++) begin
      #1;
      n_run++; if (stall !== exp_stall[i]) begin n_fail++; $display("FAIL sv_stall[%0d] got %0h want %0h", i, stall, exp_stall[i]); end
      n_run++; if (dbg_gnt !== (i == 7)) begin n_fail++; $display("FAIL sv_gnt[%0d] got %0h want %0h", i, dbg_gnt, i == 7); end
      n_run++; if (dbg_done !== (i == 9)) begin n_fail++; $display("FAIL sv_done[%0d] got %0h want %0h", i, dbg_done, i == 9); end
      if (i == 7) begin
        n_run++; if (dm_addr !== 32'h20) begin n_fail++; $display("FAIL sv_dbg_addr got %h want 20", dm_addr); end
        dbg_req = 0;
      end
      if (i == 11) begin
        n_run++; if (cpu_rdata !== 32'hA5000040) begin n_fail++; $display("FAIL sv_rdata got %h want a5000040", cpu_rdata); end
      end
      tick();
    end
    cpu_read = 0;
  endtask

  task automatic test_same_cycle;
    tick();
    cpu_read = 1; cpu_addr = 32'h50;
    dbg_req = 1; dbg_we = 0; dbg_addr = 32'h20;
    #1;
    n_run++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sc_stall got %0h want 1", stall); end
    tick(); #1;
    n_run++; if (dm_addr !== 32'h50) begin n_fail++; $display("FAIL sc_cpu_first got %h want 50", dm_addr); end
    n_run++; if (dbg_gnt !== 1'b0) begin n_fail++; $display("FAIL sc_gnt_early got %0h want 0", dbg_gnt); end
    tick(); #1;
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sc_stall_end got %0h want 0", stall); end
    tick();
    cpu_read = 0;
    #1;
    n_run++; if (dm_read !== 1'b0) begin n_fail++; $display("FAIL sc_idle got %0h want 0", dm_read); end
    tick(); #1;
    n_run++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL sc_gnt got %0h want 1", dbg_gnt); end
    n_run++; if (dm_addr !== 32'h20) begin n_fail++; $display("FAIL sc_dbg_addr got %h want 20", dm_addr); end
    dbg_req = 0;
    tick(); tick(); #1;
    n_run++; if (dbg_done !== 1'b1) begin n_fail++; $display("FAIL sc_done got %0h want 1", dbg_done); end
  endtask

  task automatic test_lat1_both;
    tick();
    c1_read = 1; c1_write = 1; c1_addr = 32'h60; c1_wdata = 32'hDEAD;
    #1;
    n_run++; if (c1_stall !== 1'b1) begin n_fail++; $display("FAIL l1_stall0 got %0h want 1", c1_stall); end
    n_run++; if (c1_dm_write !== 1'b0) begin n_fail++; $display("FAIL l1_write_idle got %0h want 0", c1_dm_write); end
    tick(); #1;
    n_run++; if (c1_stall !== 1'b0) begin n_fail++; $display("FAIL l1_stall1 got %0h want 0", c1_stall); end
    n_run++; if (c1_dm_write !== 1'b1) begin n_fail++; $display("FAIL l1_write got %0h want 1", c1_dm_write); end
    n_run++; if (c1_dm_read !== 1'b0) begin n_fail++; $display("FAIL l1_read got %0h want 0", c1_dm_read); end
    n_run++; if (c1_dm_wdata !== 32'hDEAD) begin n_fail++; $display("FAIL l1_wdata got %h want dead", c1_dm_wdata); end
    tick();
    c1_read = 0; c1_write = 0;
    #1;
    n_run++; if (c1_dm_write !== 1'b0) begin n_fail++; $display("FAIL l1_after got %0h want 0", c1_dm_write); end
  endtask

  task automatic test_reset_mid;
    tick();
    dbg_req = 1; dbg_we = 1; dbg_addr = 32'h70; dbg_wdata = 32'h77;
    tick(); #1;
    n_run++; if (dbg_gnt !== 1'b1) begin n_fail++; $display("FAIL rm_gnt got %0h want 1", dbg_gnt); end
    dbg_req = 0;
    tick(); #1;
    n_run++; if (dm_write !== 1'b1) begin n_fail++; $display("FAIL rm_write_pre got %0h want 1", dm_write); end
    rst_n = 0; cpu_read = 1;
    #1;
    n_run++; if (dm_write !== 1'b0) begin n_fail++; $display("FAIL rm_write_async got %0h want 0", dm_write); end
    n_run++; if (dm_addr !== 32'd0) begin n_fail++; $display("FAIL rm_addr_async got %h want 0", dm_addr); end
    n_run++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall got %0h want 0", stall); end
    tick(); #1;
    n_run++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL rm_done_rst got %0h want 0", dbg_done); end
    cpu_read = 0;
    tick();
    rst_n = 1;
    #1;
    n_run++; if (dm_write !== 1'b0) begin n_fail++; $display("FAIL rm_idle got %0h want 0", dm_write); end
    tick(); #1;
    n_run++; if (dbg_done !== 1'b0) begin n_fail++; $display("FAIL rm_done_rel got %0h want 0", dbg_done); end
    cpu_read = 1; cpu_addr = 32'h10;
    #1;
    n_run++; if (dm_read !== 1'b0) begin n_fail++; $display("FAIL rm_rd_idle got %0h want 0", dm_read); end
    n_run++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rm_rd_stall got %0h want 1", stall); end
    tick(); #1;
    n_run++; if (dm_read !== 1'b1) begin n_fail++; $display("FAIL rm_rd_acc got %0h want 1", dm_read); end
    tick(); tick();
    cpu_read = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_dbg_read();
    test_dbg_write();
    test_starvation();
    test_same_cycle();
    test_lat1_both();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
